// File: rtl/uart_pkg.sv
// Shared definitions for the uarttx transmit-side controller.
package uart_pkg;
  localparam int TX_W           = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    C_IDLE     = 2'b00,
    C_ISSUE    = 2'b01,
    C_WAITBUSY = 2'b11,
    C_WAITDONE = 2'b10
  } ctrl_state_t;
endpackage

// File: rtl/uarttx_fifo.sv
// Shared byte FIFO between the requester arbiter and the transmit sequencer.
module uarttx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int PTR_SZ     = 2
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              push,
  input  logic [TX_W-1:0]   din,
  input  logic              pop,
  output logic [TX_W-1:0]   dout,
  output logic [PTR_SZ:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [PTR_SZ:0]   CNT_ONE  = (PTR_SZ+1)'(1);
  localparam logic [PTR_SZ:0]   CNT_FULL = (PTR_SZ+1)'(FIFO_DEPTH);
  localparam logic [PTR_SZ-1:0] PTR_ONE  = PTR_SZ'(1);

  logic [TX_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_SZ-1:0] wr_ptr;
  logic [PTR_SZ-1:0] rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(negedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(negedge clk) begin
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uarttx_ctrl.sv
// Round-robin arbiter for two byte sources feeding one uarttx serialiser,
// plus the sequencer that drives the serialiser's write/idle handshake.
module uarttx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int PTR_SZ     = 2
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic [TX_W-1:0]   req0_data,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [TX_W-1:0]   req1_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  output logic [TX_W-1:0]   tx_din,
  output logic              tx_wr,
  input  logic              tx_idle,
  output logic [PTR_SZ:0]   level,
  output logic              busy
);

  ctrl_state_t     state;
  logic            last_grant;
  logic            full;
  logic            empty;
  logic            push0;
  logic            push1;
  logic            push;
  logic            pop;
  logic [TX_W-1:0] push_data;
  logic [TX_W-1:0] head;

  // The two readies can never both be high while both requesters are valid,
  // so at most one push happens per cycle.
  assign req0_ready = reset_b & ~full & (~req1_valid | last_grant);
  assign req1_ready = reset_b & ~full & (~req0_valid | ~last_grant);
  assign push0      = req0_valid & req0_ready;
  assign push1      = req1_valid & req1_ready;
  assign push       = push0 | push1;
  assign push_data  = push0 ? req0_data : req1_data;

  assign pop  = (state == C_IDLE) & ~empty & tx_idle;
  assign busy = ~empty | (state != C_IDLE);

  uarttx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .PTR_SZ     (PTR_SZ)
  ) u_fifo (
    .clk     (clk),
    .reset_b (reset_b),
    .push    (push),
    .din     (push_data),
    .pop     (pop),
    .dout    (head),
    .count   (level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(negedge clk) begin
    if (!reset_b) begin
      last_grant <= 1'b1;
    end else if (push0) begin
      last_grant <= 1'b0;
    end else if (push1) begin
      last_grant <= 1'b1;
    end
  end

  // WAITBUSY guards against re-issuing before the serialiser has taken the byte.
  always_ff @(negedge clk) begin
    if (!reset_b) begin
      state  <= C_IDLE;
      tx_wr  <= 1'b0;
      tx_din <= '0;
    end else begin
      tx_wr <= 1'b0;
      case (state)
        C_IDLE: begin
          if (pop) begin
            tx_din <= head;
            tx_wr  <= 1'b1;
            state  <= C_ISSUE;
          end
        end
        C_ISSUE: begin
          state <= C_WAITBUSY;
        end
        C_WAITBUSY: begin
          if (!tx_idle) begin
            state <= C_WAITDONE;
          end
        end
        C_WAITDONE: begin
          if (tx_idle) begin
            state <= C_IDLE;
          end
        end
        default: begin
          state <= C_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uarttx_ctrl.sv
// Bench for uarttx_ctrl: behavioural serialiser, queue-based reference model,
// per-cycle output comparison and directed scenarios with literal expectations.
module tb_uarttx_ctrl;
  localparam int DEPTH = 4;
  localparam int FRAME = 160;

  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_valid = 1'b0;
  logic       req0_ready;
  logic [7:0] req1_data = 8'h00;
  logic       req1_valid = 1'b0;
  logic       req1_ready;
  logic [7:0] tx_din;
  logic       tx_wr;
  logic       tx_idle = 1'b1;
  logic [2:0] level;
  logic       busy;

  uarttx_ctrl #(.FIFO_DEPTH(DEPTH), .PTR_SZ(2)) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .req0_data  (req0_data),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req1_data  (req1_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .tx_din     (tx_din),
    .tx_wr      (tx_wr),
    .tx_idle    (tx_idle),
    .level      (level),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  logic [7:0] src0[$];
  logic [7:0] src1[$];
  logic [7:0] mq[$];
  logic [7:0] cap_q[$];
  int         cap_e[$];
  int         p0 = 0;
  int         p1 = 0;
  int         acc0_e = 0;
  int         acc1_e = 0;
  int         edge_n = 0;
  int         rise_e = 0;
  int         scnt = 0;

  bit         mdl_lg = 1;
  bit         mdl_free = 1;
  bit         saw_low = 0;
  logic       exp_wr = 1'b0;
  logic [7:0] exp_din = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Serialiser stand-in: captures on host_wr, idle low for one full frame.
  always @(negedge clk) begin
    edge_n = edge_n + 1;
    if (!reset_b) begin
      scnt = 0;
      tx_idle <= 1'b1;
    end else if (scnt == 0) begin
      if (tx_wr) begin
        cap_q.push_back(tx_din);
        cap_e.push_back(edge_n);
        scnt = FRAME;
        tx_idle <= 1'b0;
      end
    end else begin
      scnt = scnt - 1;
      if (scnt == 0) begin
        tx_idle <= 1'b1;
        rise_e = edge_n;
      end
    end
  end

  // Reference model: accepted bytes in a queue, round-robin by last winner,
  // a byte leaves when the queue is non-empty, the transmitter is free and
  // the line is idle; the transmitter is free again one edge after idle returns.
  always @(negedge clk) begin
    bit         full_m;
    bit         r0;
    bit         r1;
    bit         do_pop;
    if (!reset_b) begin
      mq.delete();
      mdl_lg   = 1;
      mdl_free = 1;
      saw_low  = 0;
      exp_wr   = 1'b0;
      exp_din  = 8'h00;
    end else begin
      full_m = (mq.size() == DEPTH);
      r0 = !full_m && (!req1_valid || mdl_lg);
      r1 = !full_m && (!req0_valid || !mdl_lg);
      do_pop = (mq.size() > 0) && mdl_free && (tx_idle == 1'b1);
      if (!mdl_free) begin
        if (tx_idle == 1'b0) saw_low = 1;
        else if (saw_low) mdl_free = 1;
      end
      exp_wr = do_pop;
      if (do_pop) begin
        exp_din  = mq.pop_front();
        mdl_free = 0;
        saw_low  = 0;
      end
      if (req0_valid && r0) begin
        mq.push_back(req0_data);
        mdl_lg = 0;
      end else if (req1_valid && r1) begin
        mq.push_back(req1_data);
        mdl_lg = 1;
      end
    end
  end

  always @(posedge clk) begin
    if (chk_on) begin
      chk("req0_ready", 32'(req0_ready),
          32'(reset_b && (mq.size() < DEPTH) && (!req1_valid || mdl_lg)));
      chk("req1_ready", 32'(req1_ready),
          32'(reset_b && (mq.size() < DEPTH) && (!req0_valid || !mdl_lg)));
      chk("level", 32'(level), 32'(mq.size()));
      chk("tx_wr", 32'(tx_wr), 32'(exp_wr));
      chk("tx_din", 32'(tx_din), 32'(exp_din));
      chk("busy", 32'(busy), 32'((mq.size() > 0) || !mdl_free));
    end
  end

  // Requester drivers: valid with probability pN while bytes are pending.
  initial begin
    bit a0;
    bit a1;
    forever begin
      @(posedge clk);
      #1;
      req0_valid = (src0.size() > 0) && ($urandom_range(99) < p0);
      req0_data  = req0_valid ? src0[0] : 8'($urandom);
      req1_valid = (src1.size() > 0) && ($urandom_range(99) < p1);
      req1_data  = req1_valid ? src1[0] : 8'($urandom);
      #1;
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(negedge clk);
      #1;
      if (a0) begin void'(src0.pop_front()); acc0_e = edge_n; end
      if (a1) begin void'(src1.pop_front()); acc1_e = edge_n; end
    end
  end

  task automatic wait_idle(input logic val, input int lim, input string nm);
    int k = 0;
    while (tx_idle !== val && k < lim) begin @(posedge clk); k++; end
    chk(nm, 32'(tx_idle), 32'(val));
  endtask

  task automatic wait_level(input int val, input int lim, input string nm);
    int k = 0;
    while (level !== 3'(val) && k < lim) begin @(posedge clk); k++; end
    chk(nm, 32'(level), 32'(val));
  endtask

  task automatic wait_src0_empty(input int lim, input string nm);
    int k = 0;
    while (src0.size() != 0 && k < lim) begin @(posedge clk); k++; end
    chk(nm, 32'(src0.size()), 32'd0);
  endtask

  task automatic wait_drain(input int lim, input string nm);
    int k = 0;
    while (!(src0.size() == 0 && src1.size() == 0 && mq.size() == 0 && mdl_free && tx_idle)
           && k < lim) begin
      @(posedge clk); k++;
    end
    chk(nm, 32'(k < lim), 32'd1);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset_b = 1'b0;
    @(posedge clk); #1 reset_b = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int idx;
    int r;
    logic [7:0] exp_ord [12];
    reset_b = 1'b0;
    repeat (3) @(posedge clk);
    chk_on = 1;
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_tx_wr", 32'(tx_wr), 32'd0);
    chk("rst_tx_din", 32'(tx_din), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    #1 reset_b = 1'b1;
    #1;
    chk("rel_req0_ready", 32'(req0_ready), 32'd1);
    chk("rel_req1_ready", 32'(req1_ready), 32'd1);

    // Single byte: write strobe two edges after acceptance.
    @(posedge clk);
    base = cap_q.size();
    p0 = 100; p1 = 100;
    src0.push_back(8'hA5);
    wait_idle(1'b0, 20, "a5_start");
    chk("a5_count", 32'(cap_q.size()), 32'(base + 1));
    if (cap_q.size() > base) begin
      chk("a5_byte", 32'(cap_q[base]), 32'hA5);
      chk("a5_latency", 32'(cap_e[base] - acc0_e), 32'd2);
    end
    wait_drain(400, "a5_drain");

    // Contention from reset: requester 0 wins first, then strict alternation.
    do_reset();
    base = cap_q.size();
    for (int i = 0; i < 6; i++) begin
      src0.push_back(8'(8'h10 + i));
      src1.push_back(8'(8'h20 + i));
      exp_ord[2*i]   = 8'(8'h10 + i);
      exp_ord[2*i+1] = 8'(8'h20 + i);
    end
    wait_drain(3000, "rr_drain");
    chk("rr_count", 32'(cap_q.size()), 32'(base + 12));
    for (int i = 0; i < 12; i++) begin
      if (base + i < cap_q.size()) chk("rr_order", 32'(cap_q[base + i]), 32'(exp_ord[i]));
    end

    // Full: fifth byte waits for the pop that drops level to 3.
    @(posedge clk);
    p1 = 0;
    src0.push_back(8'hB0);
    wait_idle(1'b0, 20, "full_start");
    @(posedge clk);
    for (int i = 1; i <= 5; i++) src0.push_back(8'(8'hC0 + i));
    wait_level(4, 20, "full_level4");
    #2;
    chk("full_ready0", 32'(req0_ready), 32'd0);
    wait_src0_empty(400, "full_c5_accepted");
    idx = -1;
    for (int i = 0; i < cap_q.size(); i++) if (cap_q[i] == 8'hC1) idx = i;
    chk("full_c1_sent", 32'(idx >= 0), 32'd1);
    if (idx >= 0) chk("full_accept_edge", 32'(acc0_e), 32'(cap_e[idx]));
    wait_drain(1500, "full_drain");

    // Push coinciding with a pop; also the back-to-back gap.
    @(posedge clk);
    src0.push_back(8'hD0);
    wait_idle(1'b0, 20, "pp_start");
    @(posedge clk);
    src0.push_back(8'hD1);
    wait_level(1, 20, "pp_level1");
    wait_idle(1'b1, 300, "pp_rise");
    r = rise_e;
    @(posedge clk);
    src0.push_back(8'hD2);
    @(posedge clk);
    #2;
    chk("pp_level_same", 32'(level), 32'd1);
    chk("pp_push_edge", 32'(acc0_e), 32'(r + 2));
    base = cap_q.size();
    wait_drain(600, "pp_drain");
    chk("pp_count", 32'(cap_q.size()), 32'(base + 2));
    if (cap_q.size() >= base + 2) begin
      chk("pp_first", 32'(cap_q[base]), 32'hD1);
      chk("pp_second", 32'(cap_q[base + 1]), 32'hD2);
      chk("b2b_gap", 32'(cap_e[base] - r), 32'd3);
    end

    // Reset 50 cycles into a frame with three bytes queued.
    @(posedge clk);
    for (int i = 0; i < 4; i++) src0.push_back(8'(8'hE0 + i));
    wait_idle(1'b0, 20, "mr_start");
    repeat (50) @(posedge clk);
    chk("mr_level3", 32'(level), 32'd3);
    #1 reset_b = 1'b0;
    @(posedge clk); #1 reset_b = 1'b1;
    #1;
    chk("mr_level", 32'(level), 32'd0);
    chk("mr_tx_wr", 32'(tx_wr), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_req0_ready", 32'(req0_ready), 32'd1);
    base = cap_q.size();
    repeat (400) @(posedge clk);
    chk("mr_no_frames", 32'(cap_q.size()), 32'(base));

    // Randomised traffic against the model.
    for (int rnd = 0; rnd < 3; rnd++) begin
      @(posedge clk);
      base = cap_q.size();
      p0 = $urandom_range(100, 20);
      p1 = $urandom_range(100, 20);
      for (int i = 0; i < 12; i++) begin
        src0.push_back(8'($urandom));
        src1.push_back(8'($urandom));
      end
      wait_drain(6000, "rnd_drain");
      chk("rnd_count", 32'(cap_q.size()), 32'(base + 24));
    end

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uarttx_ctrl.md
# uarttx_ctrl

Transmit-side controller that shares one `uarttx` serialiser between two byte sources: the host CPU port (requester 0) and the monitor/debug port (requester 1). Bytes are accepted by round-robin arbitration into a small shared FIFO. A sequencing FSM pops the FIFO and drives the serialiser's `host_wr`/`host_dir` handshake so that every byte is issued exactly once. The block sits between the bus-side write decoders and `uarttx`, in the same clock domain.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: shared FIFO entries; must be a power of 2, ≥ 2.
- `PTR_SZ`, 2: log2(FIFO_DEPTH).

Ports:
- `clk`  in  1  system clock; all flops update on the falling edge, matching `uarttx`.
- `reset_b`  in  1  reset, synchronous, active-low.
- `req0_data`  in  8  requester 0 byte.
- `req0_valid`  in  1  requester 0 has a byte.
- `req0_ready`  out  1  requester 0 byte is accepted at the next edge if valid.
- `req1_data`, `req1_valid`, `req1_ready`: same as above for requester 1.
- `tx_din`  out  8  byte to serialiser; connects to `uarttx.din`.
- `tx_wr`  out  1  one-cycle write strobe; connects to `uarttx.host_wr`.
- `tx_idle`  in  1  serialiser idle; connects to `uarttx.host_dir`.
- `level`  out  PTR_SZ+1  FIFO occupancy, 0..FIFO_DEPTH.
- `busy`  out  1  FIFO non-empty or FSM not in C_IDLE.

## Operation
- Acceptance: `reqN_ready` is combinational from registered state.
  - `req0_ready = reset_b & ~full & (~req1_valid | last_grant==1)`.
  - `req1_ready = reset_b & ~full & (~req0_valid | last_grant==0)`.
  - At most one push per cycle. The push fires when valid & ready. `last_grant` updates to the accepted requester.
- Round-robin: `last_grant` resets to 1, so requester 0 wins the first contention. A lone valid requester is always granted when not full.
- Full: no pass-through. When `level==FIFO_DEPTH`, both readies are 0 even if a pop occurs in the same cycle.
- Simultaneous push and pop: both happen and `level` is unchanged. The FIFO is first-in first-out across requesters in acceptance order.
- FSM states:
  - C_IDLE: if FIFO non-empty and `tx_idle`=1, latch the head into `tx_din`, pop, and go to C_ISSUE.
  - C_ISSUE: `tx_wr`=1 for exactly this cycle, then go to C_WAITBUSY.
  - C_WAITBUSY: stay until `tx_idle`=0, then go to C_WAITDONE.
  - C_WAITDONE: stay until `tx_idle`=1, then go to C_IDLE.
- `tx_wr` is a registered output and is high only in C_ISSUE. `tx_din` holds its value until the next pop.
- Reset (any cycle, including mid-frame): FIFO is emptied, FSM goes to C_IDLE, `last_grant`=1, and the pending byte is discarded. `uarttx` shares `reset_b` and returns to idle.

## Timing
- Reset values:
  - `tx_wr`=0, `tx_din`=8'h00, `level`=0, `busy`=0.
  - `req0_ready`=`req1_ready`=0 while `reset_b`=0, and 1 in the first cycle after release.
- Latency, empty FIFO with serialiser idle:
  - Push at edge n.
  - Pop and enter C_ISSUE at edge n+1.
  - `uarttx` captures `tx_din` at edge n+2; start bit begins after edge n+2.
- Frame: with 16 ticks per bit, `tx_idle` is low for 160 cycles per byte.
- Back-to-back: `tx_idle` rises at edge m. C_WAITDONE→C_IDLE at edge m+1, pop at m+2, capture at m+3. The gap between frames is 3 cycles of idle-high line in addition to the stop bit.
- `level` is registered and reflects pushes/pops on the same edge.

## Structure
- Shared package `uart_pkg`:
  - FSM encodings C_IDLE=2'b00, C_ISSUE=2'b01, C_WAITBUSY=2'b11, C_WAITDONE=2'b10.
  - TX word size 8.
  - Default FIFO_DEPTH.
- One sub-module, `uarttx_fifo`:
  - FIFO_DEPTH×8 register array.
  - Read/write pointers of PTR_SZ bits that wrap naturally.
  - Count of PTR_SZ+1 bits; full/empty derived from the count.
  - Synchronous active-low reset.
- Arbiter and FSM live in `uarttx_ctrl`.

## Test plan
- Single byte: req0 pushes 8'hA5 after reset → `tx_wr` high for 1 cycle, 2 edges after the push, with `tx_din`=8'hA5. Serial line shows start, bits 1,0,1,0,0,1,0,1 (LSB first), then stop, 160 cycles total. `busy` drops after `tx_idle` returns.
- Contention: req0 and req1 hold valid continuously with 8'h10.. and 8'h20.. → acceptance order 10,20,11,21,… and transmitted order identical.
- Full: req0 pushes 5 bytes while the serialiser is busy → `level` reaches 4 and `req0_ready`=0. The 5th byte is accepted only on the edge after a pop drops `level` to 3.
- Push/pop same cycle: `level`=1 and a push coincides with a C_IDLE pop → `level` stays 1, and both bytes are transmitted in order.
- Reset mid-frame: assert `reset_b`=0 for 1 cycle 50 cycles into a frame with 3 bytes queued → `level`=0, `tx_wr`=0, and the line returns to 1. No further frames are sent, and `req0_ready`=1 after release.
- Back-to-back gap: two queued bytes → the second `tx_wr` occurs exactly 2 edges after C_WAITDONE exits, i.e. 3 cycles after `tx_idle` rises.
